// File: rtl/usb_rx_pkg.sv
// Shared constants and types for the USB receive bit-timing path.
package usb_rx_pkg;

  localparam int USB_CLKS_PER_BIT_DEF = 8;
  localparam int USB_SAMPLE_POINT_DEF = 3;
  localparam int USB_BITS_PER_BYTE    = 8;

  typedef logic [2:0] ones_t;
  typedef logic [2:0] bitc_t;

  localparam ones_t USB_STUFF_LIMIT = 3'd6;
  localparam bitc_t USB_BITC_MAX    = 3'(USB_BITS_PER_BYTE - 1);

endpackage

// File: rtl/usb_flex_counter.sv
// Wrapping up-counter with synchronous clear/load, count enable and a
// combinational flag that is high while the count sits at its rollover value.
module usb_flex_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             count_enable,
  input  logic [WIDTH-1:0] rollover_val,
  output logic [WIDTH-1:0] count_out,
  output logic             rollover_flag
);

  logic [WIDTH-1:0] count_reg;
  logic [WIDTH-1:0] count_next;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) count_reg <= '0;
    else        count_reg <= count_next;
  end

  // Clear beats load beats count.
  always_comb begin
    count_next = count_reg;
    if (clear)
      count_next = '0;
    else if (load)
      count_next = load_val;
    else if (count_enable)
      count_next = (count_reg == rollover_val) ? '0 : count_reg + 1'b1;
  end

  assign count_out     = count_reg;
  assign rollover_flag = (count_reg == rollover_val);

endmodule

// File: rtl/usb_rx_timer.sv
// USB RX bit timing and bit unstuffing. Defining USB_RX_RESYNC_EN lets each
// d_edge realign the sample phase; otherwise the phase free-runs per packet.
module usb_rx_timer
  import usb_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = USB_CLKS_PER_BIT_DEF,
  parameter int SAMPLE_POINT = USB_SAMPLE_POINT_DEF
) (
  input  logic clk,
  input  logic n_rst,
  input  logic rcving,
  input  logic d_edge,
  input  logic d_orig,
  output logic shift_enable,
  output logic data_shift,
  output logic byte_received,
  output logic stuff_err
);

  localparam int PW = $clog2(CLKS_PER_BIT);
  localparam logic [PW-1:0] PHASE_MAX    = PW'(CLKS_PER_BIT - 1);
  localparam logic [PW-1:0] PHASE_SAMPLE = PW'(SAMPLE_POINT);
  localparam logic [PW-1:0] PHASE_RESYNC = PW'(1);

  logic          rcving_reg;
  logic [PW-1:0] phase;
  logic          phase_load;
  logic          unused_phase_roll;
  bitc_t         bitc;
  logic          bitc_roll;
  ones_t         ones_reg;
  ones_t         ones_next;
  logic          is_stuff;
  logic          byte_received_reg;
  logic          stuff_err_reg;

  // The first rcving cycle holds phase at 0 so the first sample lands
  // SAMPLE_POINT+1 cycles into the packet.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) rcving_reg <= 1'b0;
    else        rcving_reg <= rcving;
  end

`ifdef USB_RX_RESYNC_EN
  assign phase_load = rcving && d_edge;
`else
  logic unused_d_edge;
  assign unused_d_edge = d_edge;
  assign phase_load    = 1'b0;
`endif

  usb_flex_counter #(.WIDTH(PW)) u_phase_cnt (
    .clk          (clk),
    .n_rst        (n_rst),
    .clear        (!rcving),
    .load         (phase_load),
    .load_val     (PHASE_RESYNC),
    .count_enable (rcving && rcving_reg),
    .rollover_val (PHASE_MAX),
    .count_out    (phase),
    .rollover_flag(unused_phase_roll)
  );

  assign shift_enable = rcving && rcving_reg && (phase == PHASE_SAMPLE);
  assign is_stuff     = (ones_reg == USB_STUFF_LIMIT);
  assign data_shift   = shift_enable && !is_stuff;

  always_comb begin
    ones_next = ones_reg;
    if (!rcving)
      ones_next = '0;
    else if (shift_enable) begin
      if (is_stuff || !d_orig) ones_next = '0;
      else                     ones_next = ones_reg + 3'd1;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) ones_reg <= '0;
    else        ones_reg <= ones_next;
  end

  usb_flex_counter #(.WIDTH(3)) u_bit_cnt (
    .clk          (clk),
    .n_rst        (n_rst),
    .clear        (!rcving),
    .load         (1'b0),
    .load_val     (3'd0),
    .count_enable (data_shift),
    .rollover_val (USB_BITC_MAX),
    .count_out    (bitc),
    .rollover_flag(bitc_roll)
  );

  // Pulses register one cycle after their causing strobe.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      byte_received_reg <= 1'b0;
      stuff_err_reg     <= 1'b0;
    end else begin
      byte_received_reg <= rcving && data_shift && bitc_roll && (bitc == USB_BITC_MAX);
      stuff_err_reg     <= rcving && shift_enable && is_stuff && d_orig;
    end
  end

  assign byte_received = byte_received_reg;
  assign stuff_err     = stuff_err_reg;

endmodule

// File: tb/tb_usb_rx_timer.sv
// Directed bench for usb_rx_timer with default parameters; resync expectations
// follow USB_RX_RESYNC_EN.
module tb_usb_rx_timer;

  logic clk = 1'b0;
  logic n_rst;
  logic rcving;
  logic d_edge;
  logic d_orig;
  logic shift_enable;
  logic data_shift;
  logic byte_received;
  logic stuff_err;

  int n_checks = 0;
  int n_pass   = 0;

  usb_rx_timer dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .rcving       (rcving),
    .d_edge       (d_edge),
    .d_orig       (d_orig),
    .shift_enable (shift_enable),
    .data_shift   (data_shift),
    .byte_received(byte_received),
    .stuff_err    (stuff_err)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Idle two cycles (with a d_edge on the falling cycle), then run a packet of
  // n bit slots: bit k of 'bits' is driven on strobe k, exp_ds gives the
  // expected data_shift per strobe, err_k/br_k are strobes whose following
  // cycle must carry stuff_err/byte_received (-1 for none).
  task automatic run_seq(input string name, input int n, input logic [15:0] bits,
                         input logic [15:0] exp_ds, input int err_k, input int br_k);
    int  last;
    int  k;
    bit  strobe;
    step();
    rcving = 1'b0;
    d_edge = 1'b1;
    @(negedge clk);
    check_val({name, ".idle_se"}, shift_enable, 1'b0);
    step();
    d_edge = 1'b1;
    @(negedge clk);
    check_val({name, ".idle_br"}, byte_received, 1'b0);
    step();
    d_edge = 1'b0;
    rcving = 1'b1;
    last = 4 + 8 * (n - 1) + 2;
    for (int c = 0; c <= last; c++) begin
      if (c > 0) step();
      strobe = (c >= 4) && ((c - 4) % 8 == 0);
      k      = (c >= 4) ? (c - 4) / 8 : 0;
      d_orig = strobe ? bits[k] : 1'($urandom());
      @(negedge clk);
      check_val({name, ".se"}, shift_enable, strobe);
      check_val({name, ".ds"}, data_shift, strobe && exp_ds[k]);
      check_val({name, ".br"}, byte_received, (br_k >= 0) && (c == 4 + 8 * br_k + 1));
      check_val({name, ".serr"}, stuff_err, (err_k >= 0) && (c == 4 + 8 * err_k + 1));
    end
  endtask

  initial begin
    bit exp_se;
    n_rst  = 1'b0;
    rcving = 1'b0;
    d_edge = 1'b0;
    d_orig = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_val("rst.se", shift_enable, 1'b0);
    check_val("rst.ds", data_shift, 1'b0);
    check_val("rst.br", byte_received, 1'b0);
    check_val("rst.serr", stuff_err, 1'b0);
    @(posedge clk);
    #1;
    n_rst = 1'b1;

    // Plain byte of zeros: strobes at 4,12,...,60, byte_received at 61.
    run_seq("byte0", 8, 16'h0000, 16'h00FF, -1, 7);
    // Six ones, stuffed 0, then data: 7 data bits in 8 strobes, byte on the 9th.
    run_seq("stuff", 9, 16'h00BF, 16'h01BF, -1, 8);
    // Stuffed slot decodes as 1: stuff_err, no data_shift, ones restarts.
    run_seq("stufferr", 9, 16'h00FF, 16'h01BF, 6, 8);
    // Abort after 5 data bits; the next byte needs 8 fresh data bits.
    run_seq("abort_part", 5, 16'h0000, 16'h001F, -1, -1);
    run_seq("abort_new", 8, 16'h0000, 16'h00FF, -1, 7);

    // Resync: edges at phase 6 (cycle 7) and at a sample cycle (cycle 10).
    step();
    rcving = 1'b0;
    step();
    rcving = 1'b1;
    for (int c = 0; c <= 14; c++) begin
      if (c > 0) step();
      d_orig = 1'($urandom());
      d_edge = (c == 7) || (c == 10);
`ifdef USB_RX_RESYNC_EN
      exp_se = (c == 4) || (c == 10) || (c == 13);
`else
      exp_se = (c == 4) || (c == 12);
`endif
      @(negedge clk);
      check_val("resync.se", shift_enable, exp_se);
    end
    step();
    d_edge = 1'b0;

    // Asynchronous reset in the middle of a sample cycle.
    rcving = 1'b0;
    step();
    rcving = 1'b1;
    d_orig = 1'b0;
    for (int c = 1; c <= 4; c++) step();
    @(negedge clk);
    check_val("async.pre_se", shift_enable, 1'b1);
    #2;
    n_rst = 1'b0;
    #1;
    check_val("async.se", shift_enable, 1'b0);
    check_val("async.ds", data_shift, 1'b0);
    check_val("async.br", byte_received, 1'b0);
    check_val("async.serr", stuff_err, 1'b0);
    @(posedge clk);
    #1;
    n_rst = 1'b1;
    for (int c = 0; c <= 5; c++) begin
      if (c > 0) step();
      @(negedge clk);
      check_val("async.restart_se", shift_enable, c == 4);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
